imm_gen_pipe: RTL

- Registered, parametrised immediate generator for the decode stage.
- Extracts the I/S/B/J/U immediates (and, optionally, the CSR zimm) from a 32-bit instruction.
- Sign-extends the result to XLEN and presents it through a valid/ready output with a 2-entry skid buffer, so decode can be pipelined without combinational ready paths.
- Also carries a sideband tag (e.g. PC or ROB id), an illegal-select flag and a wrap-around issue counter.

---
 rtl/imm_gen_pipe_pkg.sv | 21 ++
 rtl/imm_gen_pipe_extract.sv | 55 +++++
 rtl/imm_gen_pipe.sv | 106 ++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// ============================================================================
// Module   : imm_gen_pipe_pkg
// Purpose  : Immediate-format select encodings shared by the immediate pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package imm_gen_pipe_pkg;

  localparam int IMM_SEL_W = 3;

  localparam logic [IMM_SEL_W-1:0] IMM_SEL_I = 3'd0;
  localparam logic [IMM_SEL_W-1:0] IMM_SEL_S = 3'd1;
  localparam logic [IMM_SEL_W-1:0] IMM_SEL_B = 3'd2;
  localparam logic [IMM_SEL_W-1:0] IMM_SEL_J = 3'd3;
  localparam logic [IMM_SEL_W-1:0] IMM_SEL_U = 3'd4;
  localparam logic [IMM_SEL_W-1:0] IMM_SEL_Z = 3'd5;

endpackage

`default_nettype wire

// File: rtl/imm_gen_pipe_extract.sv
// ============================================================================
// Module   : imm_extract
// Purpose  : Combinational I/S/B/J/U (and optional CSR zimm) immediate decode,
//            sign-extended to XLEN (32 or 64). Zimm under IMMGEN_CSR_ZIMM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_extract
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]          instruction_i,
  input  logic [IMM_SEL_W-1:0] imm_sel_i,
  output logic [XLEN-1:0]      immediate_o,
  output logic                 illegal_o
);

  logic [31:0] w_raw;
  logic        w_unused_opcode;

  // The opcode field never contributes to any immediate format.
  assign w_unused_opcode = ^instruction_i[6:0];

  always_comb begin
    w_raw     = 32'h0;
    illegal_o = 1'b0;
    case (imm_sel_i)
      IMM_SEL_I: w_raw = {{20{instruction_i[31]}}, instruction_i[31:20]};
      IMM_SEL_S: w_raw = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
      IMM_SEL_B: w_raw = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                          instruction_i[30:25], instruction_i[11:8], 1'b0};
      IMM_SEL_J: w_raw = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                          instruction_i[20], instruction_i[30:21], 1'b0};
      IMM_SEL_U: w_raw = {instruction_i[31:12], 12'h000};
`ifdef IMMGEN_CSR_ZIMM_EN
      IMM_SEL_Z: w_raw = {27'h0, instruction_i[19:15]};
`endif
      default:   illegal_o = 1'b1;
    endcase
  end

  // Bit 31 of the 32-bit form is the sign for every format; zimm keeps it 0.
  generate
    if (XLEN > 32) begin : g_sext
      assign immediate_o = {{(XLEN-32){w_raw[31]}}, w_raw};
    end else begin : g_narrow
      assign immediate_o = w_raw[XLEN-1:0];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Registered immediate generator with 2-entry skid buffer, tag
//            sideband and issue counter. Optional zimm: IMMGEN_CSR_ZIMM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instruction,
  input  logic [IMM_SEL_W-1:0] imm_sel,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      immediate,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_illegal,
  output logic [CNT_W-1:0]     imm_count
);

  typedef struct packed {
    logic [XLEN-1:0]  immediate;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } imm_entry_t;

  imm_entry_t       main_q, main_d, skid_q, skid_d, w_new;
  logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  w_imm;
  logic             w_ill, w_in_hs, w_out_hs;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instruction_i (instruction),
    .imm_sel_i     (imm_sel),
    .immediate_o   (w_imm),
    .illegal_o     (w_ill)
  );

  assign w_new     = '{immediate: w_imm, tag: in_tag, illegal: w_ill};
  assign w_in_hs   = in_valid & ~skid_vld_q;
  assign w_out_hs  = main_vld_q & out_ready;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q + CNT_W'(w_out_hs);
    if (w_out_hs) begin
      // A full skid implies in_ready was low, so no new entry competes here.
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (w_in_hs) begin
        main_d = w_new;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (w_in_hs) begin
      if (main_vld_q) begin
        skid_d     = w_new;
        skid_vld_d = 1'b1;
      end else begin
        main_d     = w_new;
        main_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready    = ~skid_vld_q;
  assign out_valid   = main_vld_q;
  assign immediate   = main_q.immediate;
  assign out_tag     = main_q.tag;
  assign out_illegal = main_q.illegal;
  assign imm_count   = cnt_q;

endmodule

`default_nettype wire
